// File: rtl/fetch_if.sv
// Fetch-unit signal bundle: run control and decoder hints in, ROM address and status out,
// plus the branch-target LUT write port.
interface fetch_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
);
    logic              Start;
    logic [PC_W-1:0]   start_addr;
    logic              branch_en;
    logic [LUT_AW-1:0] target_sel;
    logic              halt;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   PC;
    logic              running;
    logic              Done;
    logic [15:0]       instr_count;

    modport master (
        output Start, start_addr, branch_en, target_sel, halt,
               lut_we, lut_waddr, lut_wdata,
        input  PC, running, Done, instr_count
    );

    modport slave (
        input  Start, start_addr, branch_en, target_sel, halt,
               lut_we, lut_waddr, lut_wdata,
        output PC, running, Done, instr_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED control of the ROM program counter,
// with a small branch-target LUT that is writable only while not running.
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
) (
    input  logic    CLK,
    input  logic    Reset,
    fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam int LUT_DEPTH = 1 << LUT_AW;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       count_q, count_d;
    logic              running_q, done_q;
    logic              lut_wr;
    logic [PC_W-1:0]   lut [LUT_DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        lut_wr  = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                lut_wr = bus.lut_we;
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = bus.start_addr;
                    count_d = '0;
                end
            end
            S_RUN: begin
                // Every RUN edge fetches one instruction, whichever way the PC moves.
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                if (bus.halt) begin
                    state_d = S_HALTED;
                end else if (bus.branch_en) begin
                    pc_d = lut[bus.target_sel];
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALTED);
        end
    end

    // NOTE: the LUT is reset because a branch after reset must land on a known target (zero).
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_wr) begin
            lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.running     = running_q;
    assign bus.Done        = done_q;
    assign bus.instr_count = count_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 10, program counter width in bits.
REQ-002 Parameter LUT_AW, 5, branch-target LUT address width (2^LUT_AW entries, each PC_W bits).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-high.
REQ-005 Start  input  1  request to begin execution at start_addr.
REQ-006 start_addr  input  PC_W  first instruction address.
REQ-007 branch_en  input  1  taken-branch indication from control decoder, current instruction.
REQ-008 target_sel  input  LUT_AW  branch-target LUT index taken from current instruction bits.
REQ-009 halt  input  1  decoder indication that current instruction is halt.
REQ-010 lut_we  input  1  branch-target LUT write enable.
REQ-011 lut_waddr  input  LUT_AW  LUT write index.
REQ-012 lut_wdata  input  PC_W  LUT write data (absolute target address).
REQ-013 PC  output  PC_W  registered address to instruction ROM.
REQ-014 running  output  1  registered; high while state is RUN.
REQ-015 Done  output  1  registered; high while state is HALTED.
REQ-016 instr_count  output  16  registered count of instructions fetched in RUN.

Function
REQ-017 The block SHALL implement three states: IDLE, RUN, HALTED; running and Done SHALL be decoded from state only.
REQ-018 In IDLE, Start=1 SHALL load PC<=start_addr, clear instr_count, and enter RUN on the same edge.
REQ-019 In IDLE and HALTED, PC SHALL hold; branch_en and halt SHALL be ignored.
REQ-020 In RUN, per edge, priority SHALL be halt > branch_en > sequential.
REQ-021 halt=1 in RUN: PC holds, instr_count increments, state becomes HALTED (Done=1 next cycle).
REQ-022 branch_en=1 (halt=0) in RUN: PC <= LUT[target_sel], instr_count increments.
REQ-023 Otherwise in RUN: PC <= PC+1 modulo 2^PC_W (0x3FF wraps to 0x000, no flag, no state change), instr_count increments.
REQ-024 instr_count SHALL saturate at 0xFFFF and SHALL only change in RUN or on Start.
REQ-025 Start in RUN SHALL be ignored.
REQ-026 Start in HALTED SHALL behave as in IDLE (restart): PC<=start_addr, instr_count<=0, state RUN, Done low next cycle.
REQ-027 lut_we=1 SHALL write LUT[lut_waddr]<=lut_wdata only in IDLE or HALTED; writes in RUN SHALL be dropped.
REQ-028 LUT read SHALL be combinational on target_sel; a write and Start on the same edge SHALL both take effect.
REQ-029 All outputs change only on CLK rising edge; input-to-PC latency is exactly one cycle.

Reset
REQ-030 Reset=1 at an edge SHALL override all other inputs: state IDLE, PC=0, running=0, Done=0, instr_count=0, all LUT entries 0.
REQ-031 Reset asserted mid-RUN or in HALTED SHALL abandon execution with no further PC advance; Start while Reset=1 SHALL be ignored.

Verification
REQ-032 Reset, then Start with start_addr=0x010 -> PC 0x010, 0x011, 0x012 on successive cycles; running=1, instr_count 0,1,2.
REQ-033 In IDLE write LUT[3]=0x200; start at 0x000; cycle 2 branch_en=1, target_sel=3 -> next PC 0x200; branch_en=1 with halt=1 -> PC holds, Done=1.
REQ-034 start_addr=0x3FE, no branch -> PC 0x3FE, 0x3FF, 0x000; state stays RUN.
REQ-035 halt after 4 sequential cycles -> Done=1, running=0, instr_count=5 held, PC held; Start with start_addr=0x040 -> PC=0x040, Done=0, instr_count=0.
REQ-036 lut_we=1 LUT[1]=0x155 during RUN -> later branch on target_sel=1 goes to 0x000; Reset at PC=0x123 -> next cycle PC=0, IDLE, all outputs 0.
